// File: rtl/wb_pixel_pkg.sv
// Shared constants and types for the Wishbone pixel uploader.
package wb_pixel_pkg;

    localparam int COL_W = 24;
    localparam int IDX_W = 6;

    // Register byte offsets inside the LED-control block.
    localparam logic [31:0] ADR_INIT  = 32'h00;
    localparam logic [31:0] ADR_DONE  = 32'h04;
    localparam logic [31:0] ADR_START = 32'h08;
    localparam logic [31:0] ADR_DATA  = 32'h0C;
    localparam logic [31:0] ADR_RW    = 32'h10;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_RW1,
        ST_GET_PIX,
        ST_WR_ADR,
        ST_WR_DAT,
        ST_WR_RW0,
        ST_INIT1,
        ST_POLL,
        ST_INIT0,
        ST_FIN
    } state_t;

    // Zero means one pixel; anything above the strip length is cut to it.
    function automatic logic [6:0] clamp_npix(input logic [6:0] n, input logic [6:0] max_n);
        logic [6:0] r;
        r = n;
        if (n == 7'd0) r = 7'd1;
        else if (n > max_n) r = max_n;
        return r;
    endfunction

endpackage

// File: rtl/wb_pixel_uploader_if.sv
// Wishbone classic bus seen from the uploader (master) and the register block (slave).
interface wb_pixel_uploader_if;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
        input  wb_dat_i, wb_ack_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
        output wb_dat_i, wb_ack_i
    );
endinterface

// File: rtl/wb_master_single.sv
// Single-transaction Wishbone classic engine: one request, held until ack or timeout.
module wb_master_single #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] adr,
    input  logic [31:0] wdat,
    output logic        busy,
    output logic        ack_done,
    output logic [31:0] rdat,
    output logic        timeout,
    wb_pixel_uploader_if.master wb
);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    logic [TW-1:0] stall_cnt;

    assign busy = wb.wb_cyc_o;

    // Launch, hold, and retire one bus cycle; cyc/stb drop the cycle after ack or timeout.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every register here sees pre-edge values.
        if (rst) begin
            wb.wb_cyc_o <= 1'b0;
            wb.wb_stb_o <= 1'b0;
            wb.wb_we_o  <= 1'b0;
            wb.wb_adr_o <= '0;
            wb.wb_sel_o <= '0;
            wb.wb_dat_o <= '0;
            rdat        <= '0;
            stall_cnt   <= '0;
            ack_done    <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            ack_done <= 1'b0;
            timeout  <= 1'b0;
            if (!wb.wb_cyc_o) begin
                stall_cnt <= '0;
                if (req) begin
                    wb.wb_cyc_o <= 1'b1;
                    wb.wb_stb_o <= 1'b1;
                    wb.wb_we_o  <= we;
                    wb.wb_adr_o <= adr;
                    wb.wb_sel_o <= 4'hF;
                    wb.wb_dat_o <= wdat;
                end
            end else if (wb.wb_ack_i) begin
                wb.wb_cyc_o <= 1'b0;
                wb.wb_stb_o <= 1'b0;
                wb.wb_we_o  <= 1'b0;
                wb.wb_sel_o <= '0;
                rdat        <= wb.wb_dat_i;
                ack_done    <= 1'b1;
            end else if (stall_cnt == TW'(ACK_TIMEOUT - 1)) begin
                wb.wb_cyc_o <= 1'b0;
                wb.wb_stb_o <= 1'b0;
                wb.wb_we_o  <= 1'b0;
                wb.wb_sel_o <= '0;
                timeout     <= 1'b1;
            end else begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_pixel_uploader.sv
// Pixel upload sequencer: streams colours into LED RAM, kicks a refresh, waits for done.
module wb_pixel_uploader
    import wb_pixel_pkg::*;
#(
    parameter logic [31:0] BASE_ADR    = 32'h0000_0000,
    parameter int          NPIX_MAX    = 64,
    parameter int          ACK_TIMEOUT = 255,
    parameter int          POLL_LIMIT  = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [6:0]       npix,
    input  logic             pix_valid,
    input  logic [COL_W-1:0] pix_data,
    output logic             pix_ready,
    output logic             busy,
    output logic             done,
    output logic             err,
    wb_pixel_uploader_if.master wb
);
    localparam int PW = $clog2(POLL_LIMIT + 1);

    state_t           state_q, state_d;
    logic             issued_q, issued_d;
    logic [6:0]       npix_q, npix_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [COL_W-1:0] colour_q, colour_d;
    logic [PW-1:0]    poll_q, poll_d;
    logic             err_q, err_d;

    logic             m_req, m_we, m_busy, m_ack_done, m_timeout;
    logic [31:0]      m_adr, m_wdat, m_rdat;
    logic             bus_op;
    logic             poll_hit;

    wb_master_single #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_master (
        .clk      (clk),
        .rst      (rst),
        .req      (m_req),
        .we       (m_we),
        .adr      (m_adr),
        .wdat     (m_wdat),
        .busy     (m_busy),
        .ack_done (m_ack_done),
        .rdat     (m_rdat),
        .timeout  (m_timeout),
        .wb       (wb)
    );

    assign poll_hit = (m_rdat & 32'h1) != 32'h0;
    assign busy     = (state_q != ST_IDLE) && (state_q != ST_FIN);
    assign err      = err_q;

    // Sequencer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            issued_q <= 1'b0;
            npix_q   <= '0;
            idx_q    <= '0;
            colour_q <= '0;
            poll_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            issued_q <= issued_d;
            npix_q   <= npix_d;
            idx_q    <= idx_d;
            colour_q <= colour_d;
            poll_q   <= poll_d;
            err_q    <= err_d;
        end
    end

    // Next-state, bus request selection and per-state outputs.
    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path infers a latch.
        state_d   = state_q;
        issued_d  = issued_q;
        npix_d    = npix_q;
        idx_d     = idx_q;
        colour_d  = colour_q;
        poll_d    = poll_q;
        err_d     = err_q;
        m_req     = 1'b0;
        m_we      = 1'b1;
        m_adr     = BASE_ADR;
        m_wdat    = '0;
        bus_op    = 1'b1;
        pix_ready = 1'b0;
        done      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                bus_op = 1'b0;
                if (start) begin
                    npix_d   = clamp_npix(npix, 7'(NPIX_MAX));
                    idx_d    = '0;
                    poll_d   = '0;
                    err_d    = 1'b0;
                    issued_d = 1'b0;
                    state_d  = ST_WR_RW1;
                end
            end
            ST_WR_RW1: begin
                m_adr  = BASE_ADR + ADR_RW;
                m_wdat = 32'd1;
                if (m_ack_done) state_d = ST_GET_PIX;
            end
            ST_GET_PIX: begin
                bus_op    = 1'b0;
                pix_ready = 1'b1;
                if (pix_valid) begin
                    colour_d = pix_data;
                    state_d  = ST_WR_ADR;
                end
            end
            ST_WR_ADR: begin
                m_adr  = BASE_ADR + ADR_START;
                m_wdat = {{(32-IDX_W){1'b0}}, idx_q};
                if (m_ack_done) state_d = ST_WR_DAT;
            end
            ST_WR_DAT: begin
                m_adr  = BASE_ADR + ADR_DATA;
                m_wdat = {{(32-COL_W){1'b0}}, colour_q};
                if (m_ack_done) begin
                    if ({1'b0, idx_q} + 7'd1 == npix_q) begin
                        state_d = ST_WR_RW0;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_GET_PIX;
                    end
                end
            end
            ST_WR_RW0: begin
                m_adr  = BASE_ADR + ADR_RW;
                m_wdat = 32'd0;
                if (m_ack_done) state_d = ST_INIT1;
            end
            ST_INIT1: begin
                m_adr  = BASE_ADR + ADR_INIT;
                m_wdat = 32'd1;
                if (m_ack_done) state_d = ST_POLL;
            end
            ST_POLL: begin
                m_we  = 1'b0;
                m_adr = BASE_ADR + ADR_DONE;
                if (m_ack_done) begin
                    poll_d = poll_q + 1'b1;
                    if (poll_hit) begin
                        state_d = ST_INIT0;
                    end else if (poll_q + 1'b1 == PW'(POLL_LIMIT)) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_INIT0: begin
                m_adr  = BASE_ADR + ADR_INIT;
                m_wdat = 32'd0;
                if (m_ack_done) state_d = ST_FIN;
            end
            ST_FIN: begin
                bus_op  = 1'b0;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                bus_op  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        // One request per bus state; a completed ack re-arms it for the next (or repeated) state.
        if (bus_op) begin
            m_req = !issued_q && !m_busy;
            if (m_req) issued_d = 1'b1;
            if (m_ack_done) issued_d = 1'b0;
            if (m_timeout) begin
                issued_d = 1'b0;
                err_d    = 1'b1;
                state_d  = ST_IDLE;
            end
        end
    end

endmodule

// File: doc/wb_pixel_uploader.md
Name: wb_pixel_uploader

Overview:
- Wishbone classic single-cycle bus master that drives the LED-control register block from the initiator side.
- Accepts a start command and a stream of 24-bit pixel colours.
- Writes each pixel into the LED RAM through the address, data and rw registers.
- Then pulses init, polls done until the strip refresh completes, and reports completion or timeout.
- Sits between a hardware pixel source (pattern generator or encoder-driven colour path) and the shared Wishbone bus, offloading the LM32 from per-pixel writes.

Parameters:
- BASE_ADR, 32'h0000_0000, base address of the LED-control register block.
- NPIX_MAX, 64, maximum pixel count; pixel index is 6 bits.
- ACK_TIMEOUT, 255, clock cycles to wait for wb_ack_i before aborting.
- POLL_LIMIT, 65535, maximum done-register reads before aborting.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins an upload; ignored while busy=1
- npix  in  7  pixel count, 1..NPIX_MAX; sampled on start
- pix_valid  in  1  pixel stream valid
- pix_data  in  24  pixel colour {G,R,B}
- pix_ready  out  1  pixel accepted when pix_valid&pix_ready
- busy  out  1  upload in progress
- done  out  1  one-cycle pulse on successful completion
- err  out  1  sticky timeout flag; cleared on next accepted start
- wb_cyc_o  out  1  bus cycle
- wb_stb_o  out  1  strobe
- wb_we_o  out  1  write enable
- wb_adr_o  out  32  byte address
- wb_sel_o  out  4  always 4'hF during a cycle
- wb_dat_o  out  32  write data
- wb_dat_i  in  32  read data
- wb_ack_i  in  1  acknowledge

Behaviour:
- Reset: all outputs 0; wb_adr_o and wb_dat_o 0; FSM in IDLE; counters 0.
- Bus transaction engine:
  - On request, assert cyc, stb, we, adr and dat together; hold them stable until wb_ack_i=1.
  - In the cycle after ack is sampled, deassert cyc and stb.
  - Keep at least one idle cycle between transactions; the slave ignores a request while its own ack is high.
  - Read data is captured on the ack cycle.
  - A per-transaction counter counts stalled cycles. If it reaches ACK_TIMEOUT without ack: drop cyc/stb, set err, go to IDLE, busy=0, no done pulse.
- Register offsets from BASE_ADR: INIT 0x00, DONE 0x04, START_ADD 0x08, DATA 0x0C, RW 0x10.
- FSM states and transitions:
  - IDLE: on start, latch npix, clear err, set busy, idx=0, go to WR_RW1.
  - WR_RW1: write 1 to RW → GET_PIX.
  - GET_PIX: pix_ready=1; on handshake latch the colour → WR_ADR. pix_ready is high only in this state. A stalled source holds here indefinitely; this state has no timeout.
  - WR_ADR: write {26'b0, idx} to START_ADD → WR_DAT.
  - WR_DAT: write {8'b0, colour} to DATA. Then idx+1; if idx+1==npix → WR_RW0, else GET_PIX.
  - WR_RW0: write 0 to RW → INIT1.
  - INIT1: write 1 to INIT → POLL.
  - POLL: read DONE; bit0=1 → INIT0, else repeat POLL. Each read increments poll_cnt; poll_cnt==POLL_LIMIT → err path.
  - INIT0: write 0 to INIT → FIN.
  - FIN: done=1 for one cycle, busy=0 → IDLE.
- Arithmetic and boundaries:
  - npix=0 is treated as 1.
  - npix>NPIX_MAX is clamped to NPIX_MAX.
  - idx never wraps past npix-1.
- Simultaneous events: start while busy is ignored, with no effect on the current upload.
- Reset mid-transaction: cyc/stb drop in the next cycle; any partial upload is abandoned; pixels already consumed are lost.

Decomposition:
- Package wb_pixel_pkg holds:
  - register offset constants: ADR_INIT, ADR_DONE, ADR_START, ADR_DATA, ADR_RW;
  - FSM state encoding;
  - data width constants: colour width 24, index width 6.
- Sub-module wb_master_single: the single-transaction engine, with req/we/adr/wdat in, and busy/ack_done/rdat/timeout out. The top holds only the sequencing FSM.

Test Plan:
- npix=3, colours 0x110000, 0x002200, 0x000033, slave acks after 1 cycle, DONE reads 1 on the second poll → required bus sequence:
  1. RW=1
  2. {ADR=0, DAT=0x110000}, {ADR=1, DAT=0x002200}, {ADR=2, DAT=0x000033}
  3. RW=0
  4. INIT=1
  5. two DONE reads
  6. INIT=0
  7. done pulse exactly once; busy low afterwards
- pix_valid held low for 50 cycles mid-upload → no bus activity during the stall; upload resumes at the correct idx and completes.
- Slave never acks on the WR_DAT write, ACK_TIMEOUT=16 → cyc drops after 16 cycles, err=1, busy=0, no done; the next start clears err.
- DONE always reads 0, POLL_LIMIT=8 → exactly 8 reads, then err=1.
- start pulsed again while busy, plus npix=0 and npix=100 → second start has no effect; npix=0 uploads 1 pixel; npix=100 uploads 64 pixels (idx 0..63).
- rst asserted while stb is high → cyc/stb/busy=0 the next cycle; a fresh start runs a clean upload.
